// File: rtl/bitbrick_seq_mac_pkg.sv
// Shared types and brick widths for the sequential bit-brick multiply-accumulate.
package bitbrick_seq_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int SLICE_W = 2;
    localparam int BRICK_W = 3;
    localparam int PROD_W  = 6;

endpackage

// File: rtl/bitbrick_mul.sv
// Combinational 3-bit x 3-bit signed brick multiplier producing a 6-bit signed product.
module bitbrick_mul
    import bitbrick_seq_mac_pkg::*;
(
    input  logic [BRICK_W-1:0] a,
    input  logic [BRICK_W-1:0] b,
    output logic [PROD_W-1:0]  prod
);

    logic signed [PROD_W-1:0] a_ext_s;
    logic signed [PROD_W-1:0] b_ext_s;

    // Sign-extend both bricks to the product width so the multiply is exact.
    always_comb begin
        a_ext_s = $signed({{(PROD_W-BRICK_W){a[BRICK_W-1]}}, a});
        b_ext_s = $signed({{(PROD_W-BRICK_W){b[BRICK_W-1]}}, b});
        prod    = a_ext_s * b_ext_s;
    end

endmodule

// File: rtl/bitbrick_seq_mac.sv
// Sequential bit-brick MAC: one 2-bit x 2-bit brick pair per cycle, shifted and
// accumulated into a wrapping ACC_W-bit result, with valid/ready handshakes.
module bitbrick_seq_mac
    import bitbrick_seq_mac_pkg::*;
#(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 24,
    localparam int NB      = MAX_BITS / 2,
    localparam int PW      = (NB > 2) ? $clog2(NB) : 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] x,
    input  logic [MAX_BITS-1:0] y,
    input  logic                sign_x,
    input  logic                sign_y,
    input  logic [PW-1:0]       prec_x,
    input  logic [PW-1:0]       prec_y,
    input  logic                acc_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    p
);

    localparam logic [PW:0]   NB_EXT   = (PW+1)'(NB);
    localparam logic [PW-1:0] LAST_IDX = PW'(NB - 1);

    function automatic logic [PW-1:0] clamp_prec(input logic [PW-1:0] prec);
        logic [PW-1:0] res;
        if ({1'b0, prec} >= NB_EXT) begin
            res = LAST_IDX;
        end else begin
            res = prec;
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] x_q, x_d, y_q, y_d;
    logic                sx_q, sx_d, sy_q, sy_d;
    logic [PW-1:0]       xl_q, xl_d, yl_q, yl_d;
    logic [PW-1:0]       i_q, i_d, j_q, j_d;
    logic                fin_q, fin_d;
    logic [ACC_W-1:0]    acc_q, acc_d, p_q, p_d;
    logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [SLICE_W-1:0]  x_slice_s, y_slice_s;
    logic [BRICK_W-1:0]  x_brick_s, y_brick_s;
    logic [PROD_W-1:0]   prod_s;
    logic [ACC_W-1:0]    prod_ext_s, term_s;
    logic [PW:0]         sh_s;

    // Form the current brick pair; only the top brick of a signed operand carries the sign.
    always_comb begin
        x_slice_s  = x_q[{i_q, 1'b0} +: SLICE_W];
        y_slice_s  = y_q[{j_q, 1'b0} +: SLICE_W];
        x_brick_s  = {sx_q & x_slice_s[SLICE_W-1] & (i_q == xl_q), x_slice_s};
        y_brick_s  = {sy_q & y_slice_s[SLICE_W-1] & (j_q == yl_q), y_slice_s};
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        sh_s       = {1'b0, i_q} + {1'b0, j_q};
        term_s     = prod_ext_s << {sh_s, 1'b0};
    end

    bitbrick_mul u_mul (
        .a    (x_brick_s),
        .b    (y_brick_s),
        .prod (prod_s)
    );

    // Next-state logic: capture on accept, one brick per COMPUTE cycle, then publish.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        i_d     = i_q;
        j_d     = j_q;
        fin_d   = fin_q;
        acc_d   = acc_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = x;
                    y_d     = y;
                    sx_d    = sign_x;
                    sy_d    = sign_y;
                    xl_d    = clamp_prec(prec_x);
                    yl_d    = clamp_prec(prec_y);
                    i_d     = '0;
                    j_d     = '0;
                    fin_d   = 1'b0;
                    acc_d   = acc_en ? p_q : '0;
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                // The cycle after the final brick only moves the sum to the output.
                if (fin_q) begin
                    p_d     = acc_q;
                    fin_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    acc_d = acc_q + term_s;
                    if (j_q == yl_q) begin
                        j_d = '0;
                        if (i_q == xl_q) begin
                            i_d   = '0;
                            fin_d = 1'b1;
                        end else begin
                            i_d = i_q + PW'(1);
                        end
                    end else begin
                        j_d = j_q + PW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            xl_q        <= '0;
            yl_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            fin_q       <= 1'b0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            xl_q        <= xl_d;
            yl_q        <= yl_d;
            i_q         <= i_d;
            j_q         <= j_d;
            fin_q       <= fin_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: doc/bitbrick_seq_mac.md
BITBRICK_SEQ_MAC -- requirements
Module: bitbrick_seq_mac

Interface
REQ-001 SHALL have parameter MAX_BITS, default 8, meaning maximum operand width; even, >= 2.
REQ-002 SHALL have parameter ACC_W, default 24, meaning accumulator and result width; >= 2*MAX_BITS.
REQ-003 SHALL derive local constants:
  - NB = MAX_BITS/2, the bricks per operand.
  - PW = max(1, clog2(NB)).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous active-high reset.
  - in_valid  in  1  operand request.
  - in_ready  out  1  block can accept an operand.
  - x  in  MAX_BITS  operand X; only low 2*(prec_x+1) bits used.
  - y  in  MAX_BITS  operand Y; only low 2*(prec_y+1) bits used.
  - sign_x  in  1  X is two's complement (else unsigned).
  - sign_y  in  1  Y is two's complement (else unsigned).
  - prec_x  in  PW  X brick count minus 1.
  - prec_y  in  PW  Y brick count minus 1.
  - acc_en  in  1  1: add product to held accumulator; 0: replace it.
  - out_valid  out  1  result available.
  - out_ready  in  1  consumer accepts result.
  - p  out  ACC_W  signed accumulated result.

Function
REQ-006 SHALL capture x, y, sign_x, sign_y, prec_x, prec_y and acc_en on the in_valid & in_ready cycle; later input changes have no effect on that operation.
REQ-007 SHALL clamp any prec value >= NB to NB-1.
REQ-008 SHALL have states IDLE, COMPUTE and DONE, with these transitions:
  - IDLE -> COMPUTE on accept.
  - COMPUTE -> DONE after the last brick.
  - DONE -> IDLE on out_valid & out_ready.
REQ-009 SHALL assert in_ready only in IDLE, and out_valid only in DONE.
REQ-010 SHALL, in COMPUTE, process exactly one brick pair (i,j) per cycle, iterating j fastest:
  - i = 0..Nx-1, with Nx = prec_x+1.
  - j = 0..Ny-1, with Ny = prec_y+1.
REQ-011 SHALL form each brick operand as a 3-bit signed value:
  - Low 2 bits = operand slice [2i+1:2i] for X, [2j+1:2j] for Y.
  - Bit 2 = sign_x & slice MSB, only when i == Nx-1; else 0.
  - Y is formed the same way, using sign_y and j == Ny-1.
REQ-012 SHALL compute the 6-bit signed brick product, sign-extend it to ACC_W, shift it left by 2*(i+j), and add it to the running accumulator.
REQ-013 SHALL initialise the running accumulator at accept to the held result if acc_en=1, else to 0.
REQ-014 SHALL enter DONE on the cycle after the final brick, so that out_valid rises Nx*Ny+1 cycles after the accept edge.
REQ-015 SHALL hold p stable throughout DONE, and hold p at its last value in IDLE.
REQ-016 SHALL wrap the accumulator modulo 2^ACC_W; no saturation, no overflow flag.
REQ-017 SHALL NOT accept a new operand in the DONE cycle in which the handshake completes; the earliest next accept is the following cycle in IDLE.
REQ-018 SHALL hold DONE and p indefinitely while out_ready=0.

Reset
REQ-019 SHALL, on rst=1 at a clock edge:
  - Set state to IDLE, with in_ready=1 and out_valid=0.
  - Zero p, the accumulator and the brick indices.
REQ-020 SHALL let rst take priority over every event, including mid-COMPUTE and a pending DONE handshake; the in-flight operation is discarded.

Structure
REQ-021 SHALL place in a shared package:
  - The state enumeration (IDLE, COMPUTE, DONE).
  - The brick width constants (2-bit slice, 3-bit signed brick, 6-bit product).
REQ-022 SHALL instantiate one combinational sub-module, bitbrick_mul, which multiplies two 3-bit signed operands into a 6-bit signed product.
REQ-023 SHALL keep all other logic (FSM, index counters, shifter, accumulator) in bitbrick_seq_mac.

Verification
REQ-024 SHALL cover, with MAX_BITS=8 and ACC_W=24 unless stated:
  - Signed 8x8: x=0x80, y=0x80, prec 3/3, acc_en=0 -> p=16384, out_valid 17 cycles after accept.
  - Unsigned 2x2: x=3, y=3, prec 0/0, sign 0/0 -> p=9, out_valid 2 cycles after accept.
  - Mixed: x=0x8 as signed 4-bit (prec_x=1), y=0xFF as unsigned 8-bit (prec_y=3) -> p=-2040, 9 cycles.
  - Accumulate: 5*7 with acc_en=0, then -3*4 with acc_en=1, both signed 4-bit -> p=35, then p=23.
  - Backpressure and reset: hold out_ready=0 for 10 cycles -> p, out_valid and in_ready=0 stay stable.
  - Then assert rst mid-COMPUTE of a later op -> next cycle IDLE, p=0, out_valid=0.
